multiplier_mac: RTL

MULTIPLIER_MAC -- requirements
Module: multiplier_mac

---
 rtl/multiplier_pkg.sv | 14 +
 rtl/mult_pipe.sv | 51 +++++
 rtl/multiplier_mac.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and default sizing for the multiply/accumulate block controller.
package multiplier_pkg;

    localparam int DEF_IN_WIDTH = 16;
    localparam int DEF_DEPTH    = 64;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2,
        ST_READ  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mult_pipe.sv
// Operand capture stage and full-width signed/unsigned multiplier.
module mult_pipe #(
    parameter int IN_WIDTH   = 16,
    parameter int ADDR_WIDTH = 6,
    localparam int OUT_WIDTH = 2 * IN_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [IN_WIDTH-1:0]   op_a,
    input  logic [IN_WIDTH-1:0]   op_b,
    input  logic                  sgn,
    input  logic [ADDR_WIDTH-1:0] idx,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [OUT_WIDTH-1:0]  product
);

    logic [IN_WIDTH-1:0]  a_q;
    logic [IN_WIDTH-1:0]  b_q;
    logic                 sgn_q;
    logic [OUT_WIDTH-1:0] ext_a;
    logic [OUT_WIDTH-1:0] ext_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            addr  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                addr  <= idx;
                a_q   <= op_a;
                b_q   <= op_b;
                sgn_q <= sgn;
            end
        end
    end

    // Extending both operands to the product width makes the low OUT_WIDTH
    // bits of one unsigned multiply correct for either interpretation.
    always_comb begin
        ext_a   = {{IN_WIDTH{sgn_q & a_q[IN_WIDTH-1]}}, a_q};
        ext_b   = {{IN_WIDTH{sgn_q & b_q[IN_WIDTH-1]}}, b_q};
        product = ext_a * ext_b;
    end

endmodule

// File: rtl/multiplier_mac.sv
// Block multiply/accumulate controller: fills an external memory with products
// (overwrite or read-modify-write accumulate), then streams the block back out.
//
// state  | meaning
// FILL   | accepting operand pairs, one per cycle, index 0..DEPTH-1
// DRAIN  | last pair accepted, waiting for its write to issue
// FULL   | block complete, waiting for EN_blockRead
// READ   | streaming addresses 0..DEPTH-1, data valid one cycle later
module multiplier_mac
    import multiplier_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    localparam int OUT_WIDTH  = 2 * IN_WIDTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN_mult,
    output logic                  RDY_mult,
    input  logic [IN_WIDTH-1:0]   mult_input0,
    input  logic [IN_WIDTH-1:0]   mult_input1,
    input  logic                  mode_signed,
    input  logic                  mode_acc,
    input  logic                  EN_blockRead,
    output logic                  VALID_memVal,
    output logic [OUT_WIDTH-1:0]  memVal_data,
    output logic                  EN_readMem,
    output logic [ADDR_WIDTH-1:0] readMem_addr,
    input  logic [OUT_WIDTH-1:0]  readMem_val,
    output logic                  EN_writeMem,
    output logic [ADDR_WIDTH-1:0] writeMem_addr,
    output logic [OUT_WIDTH-1:0]  writeMem_val
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    mac_state_t state;
    mac_state_t state_nxt;

    logic                  active;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] fill_idx;
    logic                  acc_q;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic                  rd_blk;
    logic                  rd_fill;
    logic                  valid_q;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [OUT_WIDTH-1:0]  s1_prod;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [OUT_WIDTH-1:0]  s2_prod;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [OUT_WIDTH-1:0]  wr_val;

    // active holds RDY_mult low through reset and releases it on the first edge after.
    assign RDY_mult = active && (state == ST_FILL);
    assign accept   = EN_mult && RDY_mult;

    mult_pipe #(
        .IN_WIDTH   (IN_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .load    (accept),
        .op_a    (mult_input0),
        .op_b    (mult_input1),
        .sgn     (mode_signed),
        .idx     (fill_idx),
        .valid   (s1_valid),
        .addr    (s1_addr),
        .product (s1_prod)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:  if (accept && (fill_idx == LAST_IDX)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wr_en && (wr_addr == LAST_IDX)) state_nxt = ST_FULL;
            ST_FULL:  if (EN_blockRead) state_nxt = ST_READ;
            ST_READ:  if (rd_cnt[ADDR_WIDTH]) state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active   <= 1'b0;
            fill_idx <= '0;
            acc_q    <= 1'b0;
            rd_cnt   <= '0;
            valid_q  <= 1'b0;
        end else begin
            active  <= 1'b1;
            valid_q <= rd_blk;
            if (accept) begin
                fill_idx <= fill_idx + 1'b1;
                if (fill_idx == '0) begin
                    acc_q <= mode_acc;
                end
            end
            if (state == ST_READ) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end
        end
    end

    // Accumulate passes read entry n one cycle after accept and write it the next.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid && acc_q;
            s2_addr  <= s1_addr;
            s2_prod  <= s1_prod;
        end
    end

    always_comb begin
        rd_blk  = (state == ST_READ) && !rd_cnt[ADDR_WIDTH];
        rd_fill = s1_valid && acc_q;
        wr_en   = acc_q ? s2_valid : s1_valid;
        wr_addr = acc_q ? s2_addr : s1_addr;
        wr_val  = acc_q ? (readMem_val + s2_prod) : s1_prod;
    end

    always_comb begin
        EN_readMem    = rd_blk || rd_fill;
        readMem_addr  = '0;
        if (rd_blk) begin
            readMem_addr = rd_cnt[ADDR_WIDTH-1:0];
        end else if (rd_fill) begin
            readMem_addr = s1_addr;
        end
        EN_writeMem   = wr_en;
        writeMem_addr = wr_en ? wr_addr : '0;
        writeMem_val  = wr_en ? wr_val : '0;
        VALID_memVal  = valid_q;
        memVal_data   = valid_q ? readMem_val : '0;
    end

endmodule
